// File: rtl/mem_wb_stage.sv
// MIPS MEM stage with MEM/WB register: performs data-memory access over a req/ack
// bus, stalls upstream while a load/store is outstanding, and aborts on timeout.
module mem_wb_stage #(
  parameter int unsigned DW       = 32,
  parameter int unsigned RW       = 5,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          RFWEM,
  input  logic          DMWEM,
  input  logic          MtoRFselM,
  input  logic [DW-1:0] ALU_outM,
  input  logic [DW-1:0] DMinM,
  input  logic [RW-1:0] RtDM,
  output logic          STALL_M,
  output logic          DM_REQ,
  output logic          DM_WE,
  output logic [DW-1:0] DM_ADDR,
  output logic [DW-1:0] DM_WDATA,
  input  logic [DW-1:0] DM_RDATA,
  input  logic          DM_ACK,
  output logic          RFWEW,
  output logic [DW-1:0] ResultW,
  output logic [RW-1:0] RtDW,
  output logic          DM_ERR
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t        state;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic [DW-1:0] rdata_q;
  logic [7:0]    wait_cnt;
  logic          memop;

  assign memop = DMWEM | MtoRFselM;

  // Gated by RSTN so the stall releases immediately when reset asserts mid-access.
  assign STALL_M  = RSTN & (((state == IDLE) & memop) | (state == REQ));
  assign DM_REQ   = (state == REQ);
  assign DM_WE    = we_q;
  assign DM_ADDR  = addr_q;
  assign DM_WDATA = wdata_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      RFWEW    <= 1'b0;
      ResultW  <= '0;
      RtDW     <= '0;
      DM_ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            addr_q   <= ALU_outM;
            wdata_q  <= DMinM;
            we_q     <= DMWEM;
            rdata_q  <= '0;
            wait_cnt <= '0;
            RFWEW    <= 1'b0;
            state    <= REQ;
          end else begin
            RFWEW   <= RFWEM & (RtDM != '0);
            ResultW <= ALU_outM;
            RtDW    <= RtDM;
          end
        end
        REQ: begin
          if (DM_ACK) begin
            if (!we_q) rdata_q <= DM_RDATA;
            state <= DONE;
          end else if (wait_cnt >= WAIT_LAST) begin
            DM_ERR  <= 1'b1;
            rdata_q <= '0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          RFWEW   <= RFWEM & (RtDM != '0);
          ResultW <= MtoRFselM ? rdata_q : ALU_outM;
          RtDW    <= RtDM;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions push expected W results,
// a monitor pops them as each instruction leaves M; a memory model answers requests.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        RFWEM = 1'b0, DMWEM = 1'b0, MtoRFselM = 1'b0;
  logic [31:0] ALU_outM = '0, DMinM = '0;
  logic [4:0]  RtDM = '0;
  logic        STALL_M, DM_REQ, DM_WE;
  logic [31:0] DM_ADDR, DM_WDATA;
  logic [31:0] DM_RDATA = '0;
  logic        DM_ACK = 1'b0;
  logic        RFWEW;
  logic [31:0] ResultW;
  logic [4:0]  RtDW;
  logic        DM_ERR;

  mem_wb_stage #(.DW(32), .RW(5), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RSTN(RSTN), .RFWEM(RFWEM), .DMWEM(DMWEM), .MtoRFselM(MtoRFselM),
    .ALU_outM(ALU_outM), .DMinM(DMinM), .RtDM(RtDM), .STALL_M(STALL_M),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK), .RFWEW(RFWEW), .ResultW(ResultW),
    .RtDW(RtDW), .DM_ERR(DM_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rfwe;
    logic [31:0] res;
    logic [4:0]  rt;
  } wb_t;

  wb_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;

  // memory model configuration: ack in the ack_at-th REQ cycle (0 = never)
  int          ack_at = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;
  int          req_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: an instruction leaves M on the edge after a non-stalled cycle
  initial begin
    wb_t e;
    bit  armed = 1'b0;
    forever begin
      @(negedge CLK);
      if (armed) begin
        chk("wb_rfwe", 64'(RFWEW), 64'(e.rfwe));
        chk("wb_result", 64'(ResultW), 64'(e.res));
        chk("wb_rt", 64'(RtDW), 64'(e.rt));
        armed = 1'b0;
      end
      if (RSTN && !STALL_M && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        armed = 1'b1;
      end
    end
  end

  // memory responder, also checks request fields stay stable
  initial begin
    forever begin
      @(negedge CLK);
      if (DM_REQ) begin
        req_cycles++;
        chk("dm_addr", 64'(DM_ADDR), 64'(exp_addr));
        chk("dm_wdata", 64'(DM_WDATA), 64'(exp_wdata));
        chk("dm_we", 64'(DM_WE), 64'(exp_we));
        if (req_cycles == ack_at) begin
          DM_ACK   = 1'b1;
          DM_RDATA = rd_val;
        end else begin
          DM_ACK   = 1'b0;
          DM_RDATA = 32'hDEAD_0000;
        end
      end else begin
        DM_ACK   = 1'b0;
        DM_RDATA = '0;
      end
    end
  end

  task automatic drive_nop();
    RFWEM = 1'b0; DMWEM = 1'b0; MtoRFselM = 1'b0;
    ALU_outM = '0; DMinM = '0; RtDM = '0;
  endtask

  task automatic issue(input logic rfwe, input logic dmwe, input logic mtorf,
                       input logic [31:0] alu, input logic [31:0] din, input logic [4:0] rt,
                       input wb_t e, output int stalls);
    bit done = 1'b0;
    RFWEM = rfwe; DMWEM = dmwe; MtoRFselM = mtorf;
    ALU_outM = alu; DMinM = din; RtDM = rt;
    exp_addr = alu; exp_wdata = din; exp_we = dmwe;
    req_cycles = 0;
    exp_q.push_back(e);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!STALL_M) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL stall_bound: STALL_M still 1 after 100 cycles, required release");
    end
    @(posedge CLK);
    #1;
    drive_nop();
  endtask

  initial begin
    int st;
    drive_nop();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", 64'(STALL_M), 64'd0);
    chk("rst_req", 64'(DM_REQ), 64'd0);
    chk("rst_w", 64'({RFWEW, ResultW, RtDW}), 64'd0);
    chk("rst_bus", 64'({DM_WE, DM_ADDR, DM_WDATA, DM_ERR}), 64'd0);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    // ALU op: single-cycle, no stall
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3, '{1'b1, 32'h10, 5'd3}, st);
    chk("alu_stalls", 64'(st), 64'd0);

    // zero-wait load
    ack_at = 1; rd_val = 32'hBEEF;
    issue(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd5, '{1'b1, 32'hBEEF, 5'd5}, st);
    chk("ld_stalls", 64'(st), 64'd2);
    chk("ld_req_cycles", 64'(req_cycles), 64'd1);

    // store, ack in third REQ cycle
    ack_at = 3; rd_val = 32'h1111_2222;
    issue(1'b0, 1'b1, 1'b0, 32'h80, 32'h55, 5'd9, '{1'b0, 32'h80, 5'd9}, st);
    chk("st_stalls", 64'(st), 64'd4);
    chk("st_req_cycles", 64'(req_cycles), 64'd3);
    chk("err_before_to", 64'(DM_ERR), 64'd0);

    // load that times out
    ack_at = 0;
    issue(1'b1, 1'b0, 1'b1, 32'h44, 32'h7, 5'd7, '{1'b1, 32'h0, 5'd7}, st);
    chk("to_req_cycles", 64'(req_cycles), 64'd15);
    chk("to_stalls", 64'(st), 64'd16);
    chk("to_err", 64'(DM_ERR), 64'd1);

    // register 0 never written
    issue(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 5'd0, '{1'b0, 32'h99, 5'd0}, st);
    issue(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd31, '{1'b1, 32'h1234, 5'd31}, st);
    chk("err_sticky", 64'(DM_ERR), 64'd1);

    // reset in the middle of a request
    ack_at = 0;
    MtoRFselM = 1'b1; RFWEM = 1'b1; ALU_outM = 32'hA0; RtDM = 5'd2;
    exp_addr = 32'hA0; exp_wdata = '0; exp_we = 1'b0; req_cycles = 0;
    repeat (2) @(negedge CLK);
    chk("mid_req_active", 64'(DM_REQ), 64'd1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_req", 64'(DM_REQ), 64'd0);
    chk("arst_stall", 64'(STALL_M), 64'd0);
    chk("arst_err", 64'(DM_ERR), 64'd0);
    drive_nop();
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    @(negedge CLK);
    chk("post_rst_req", 64'(DM_REQ), 64'd0);
    chk("post_rst_stall", 64'(STALL_M), 64'd0);
    @(posedge CLK);
    #1;
    issue(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd4, '{1'b1, 32'h77, 5'd4}, st);
    chk("post_rst_alu_stalls", 64'(st), 64'd0);
    ack_at = 2; rd_val = 32'hCAFE;
    issue(1'b1, 1'b0, 1'b1, 32'h48, 32'h0, 5'd6, '{1'b1, 32'hCAFE, 5'd6}, st);
    chk("post_rst_ld_stalls", 64'(st), 64'd3);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
